// File: rtl/mips_pkg.sv
// Shared types for the MIPS multiply/divide unit: operation codes, FSM states
// and a small operation-decode helper.
package mips_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } muldiv_state_e;

  function automatic logic op_is_signed(input muldiv_op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mips_muldiv_unit_div_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor
// when it fits and emit the quotient bit.
module mips_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             quot_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  // rem < divisor on entry, so a successful subtraction always fits in WIDTH bits
  assign shifted  = {rem, dividend_bit};
  assign diff     = shifted[WIDTH-1:0] - divisor;
  assign quot_bit = shifted >= {1'b0, divisor};
  assign rem_next = quot_bit ? diff : shifted[WIDTH-1:0];

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/DIV unit owning HI/LO, with MTHI/MTLO writes.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiply.
//  state | meaning
//  IDLE  | ready; MTHI/MTLO and one-cycle results (div-by-zero, fast multiply) retire here
//  CALC  | one shift-add or restoring-divide step per cycle, WIDTH cycles
//  FIX   | sign correction and HI/LO write-back
module mips_muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  muldiv_state_e    state, state_nxt;
  muldiv_op_e       op_e;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opnd, w_hi, w_lo;
  logic             is_div, neg_res, neg_rem, pend, pend_dz;

  logic             accept, start_mul, start_div, iter_start, sgn, a_neg, b_neg, b_zero;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] div_rem;
  logic             div_q;
  logic [2*WIDTH-1:0] fix_prod;
  logic [WIDTH-1:0] res_hi, res_lo;

  assign op_e      = muldiv_op_e'(op);
  assign op_ready  = (state == ST_IDLE) && !abort;
  assign busy      = (state != ST_IDLE);
  assign accept    = op_valid && op_ready;
  assign start_mul = accept && (op_e == OP_MULT || op_e == OP_MULTU);
  assign start_div = accept && (op_e == OP_DIV || op_e == OP_DIVU);
  assign sgn       = op_is_signed(op_e);
  assign a_neg     = sgn && src_a[WIDTH-1];
  assign b_neg     = sgn && src_b[WIDTH-1];
  assign mag_a     = a_neg ? -src_a : src_a;
  assign mag_b     = b_neg ? -src_b : src_b;
  assign b_zero    = (src_b == '0);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_a, fast_b, fast_prod;
  // Sign-extending both operands lets one unsigned multiplier serve MULT and MULTU
  assign fast_a     = {{WIDTH{a_neg}}, src_a};
  assign fast_b     = {{WIDTH{b_neg}}, src_b};
  assign fast_prod  = fast_a * fast_b;
  assign iter_start = start_div && !b_zero;
`else
  assign iter_start = start_mul || (start_div && !b_zero);
`endif

  assign mul_sum = {1'b0, w_hi} + {1'b0, (w_lo[0] ? opnd : '0)};

  mips_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem          (w_hi),
    .dividend_bit (w_lo[WIDTH-1]),
    .divisor      (opnd),
    .rem_next     (div_rem),
    .quot_bit     (div_q)
  );

  assign fix_prod = neg_res ? -{w_hi, w_lo} : {w_hi, w_lo};
  assign res_lo   = is_div ? (neg_res ? -w_lo : w_lo) : fix_prod[WIDTH-1:0];
  assign res_hi   = is_div ? (neg_rem ? -w_hi : w_hi) : fix_prod[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (iter_start) state_nxt = ST_CALC;
      ST_CALC: begin
        if (abort)                 state_nxt = ST_IDLE;
        else if (cnt == CW'(1))    state_nxt = ST_FIX;
      end
      ST_FIX:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0; opnd <= '0; w_hi <= '0; w_lo <= '0;
      is_div <= 1'b0; neg_res <= 1'b0; neg_rem <= 1'b0;
      pend <= 1'b0; pend_dz <= 1'b0;
      done <= 1'b0; div_by_zero <= 1'b0;
      hi <= '0; lo <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      // One-cycle results staged in w_hi/w_lo at accept retire on the next edge
      if (pend) begin
        hi          <= w_hi;
        lo          <= w_lo;
        done        <= 1'b1;
        div_by_zero <= pend_dz;
        pend        <= 1'b0;
        pend_dz     <= 1'b0;
      end
      if (state == ST_CALC) begin
        if (abort) begin
          cnt <= '0;
        end else begin
          cnt <= cnt - CW'(1);
          if (is_div) begin
            w_hi <= div_rem;
            w_lo <= {w_lo[WIDTH-2:0], div_q};
          end else begin
            w_hi <= mul_sum[WIDTH:1];
            w_lo <= {mul_sum[0], w_lo[WIDTH-1:1]};
          end
        end
      end
      if (state == ST_FIX && !abort) begin
        hi   <= res_hi;
        lo   <= res_lo;
        done <= 1'b1;
      end
      if (accept) begin
        case (op_e)
          OP_MTHI: hi <= src_a;
          OP_MTLO: lo <= src_a;
          OP_MULT, OP_MULTU: begin
`ifdef MULDIV_FAST_MUL_EN
            {w_hi, w_lo} <= fast_prod;
            pend         <= 1'b1;
`else
            opnd    <= mag_a;
            w_hi    <= '0;
            w_lo    <= mag_b;
            is_div  <= 1'b0;
            neg_res <= a_neg ^ b_neg;
            cnt     <= CW'(WIDTH);
`endif
          end
          OP_DIV, OP_DIVU: begin
            if (b_zero) begin
              w_hi    <= src_a;
              w_lo    <= '1;
              pend    <= 1'b1;
              pend_dz <= 1'b1;
            end else begin
              opnd    <= mag_b;
              w_hi    <= '0;
              w_lo    <= mag_a;
              is_div  <= 1'b1;
              neg_res <= a_neg ^ b_neg;
              neg_rem <= a_neg;
              cnt     <= CW'(WIDTH);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
